// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / divide unit: one bit per cycle (shift-add or
// restoring shift-subtract), followed by a sign-correction step.
module muldiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        result_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [63:0] prod
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          op_q;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] part;
    logic [4:0]          cnt;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    // Signed ops work on magnitudes; restore the signs here. A zero divisor
    // leaves the raw {dividend, all-ones} pattern untouched.
    function automatic logic [2*DATA_W-1:0] fix_sign(
        input logic [1:0]          f_op,
        input logic                sa,
        input logic                sb,
        input logic                div0,
        input logic [2*DATA_W-1:0] raw
    );
        logic signed [DATA_W-1:0] q;
        logic signed [DATA_W-1:0] r;
        q = (sa ^ sb) ? -raw[DATA_W-1:0] : raw[DATA_W-1:0];
        r = sa ? -raw[2*DATA_W-1:DATA_W] : raw[2*DATA_W-1:DATA_W];
        case (f_op)
            2'b01:   return (sa ^ sb) ? -raw : raw;
            2'b11:   return div0 ? raw : {r, q};
            default: return raw;
        endcase
    endfunction

    assign busy  = (state != IDLE);
    assign stall = busy && (start || result_req);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !cancel) state_nxt = RUN;
            RUN:     if (cancel) state_nxt = IDLE;
                     else if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mul_sum   = {1'b0, part[2*DATA_W-1:DATA_W]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {part[2*DATA_W-1:DATA_W], a_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_rem   = div_ge ? DATA_W'(div_shift - {1'b0, b_q}) : div_shift[DATA_W-1:0];

    // Operand capture and iteration stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= 2'b00;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            part   <= '0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (start && !cancel) begin
                op_q   <= op;
                sign_a <= src_a[DATA_W-1];
                sign_b <= src_b[DATA_W-1];
                a_q    <= op[0] ? abs_val(src_a) : src_a;
                b_q    <= op[0] ? abs_val(src_b) : src_b;
                part   <= '0;
                cnt    <= '0;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            if (!op_q[1]) begin
                part <= {mul_sum, part[DATA_W-1:1]};
                b_q  <= b_q >> 1;
            end else begin
                part <= {div_rem, part[DATA_W-2:0], div_ge};
                a_q  <= a_q << 1;
            end
        end
    end

    // Result stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
            prod <= '0;
        end else begin
            done <= 1'b0;
            if (state == FIX && !cancel) begin
                done <= 1'b1;
                prod <= fix_sign(op_q, sign_a, sign_b, op_q[1] && (b_q == '0), part);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of arithmetic vectors plus sequences
// for cancel, stall/back-to-back issue and mid-operation reset.
module tb_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        result_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [63:0] prod;

    int checks = 0;
    int errors = 0;

    muldiv_seq dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .cancel     (cancel),
        .result_req (result_req),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .prod       (prod)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called right after the accepting edge; lat counts that edge as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (lat < 100) begin
            tick();
            lat++;
            if (done) return;
        end
        lat = 999;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        op    = ~o;
        src_a = ~a;
        src_b = $urandom;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat;
        issue(o, a, b);
        wait_done(lat);
        check({name, "_latency"}, 64'(lat), 64'd34);
        check({name, "_prod"}, prod, exp);
        tick();
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int dcount;
        logic [63:0] saved;

        vecs[0]  = '{MULT,  32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[1]  = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC};
        vecs[4]  = '{DIVU,  32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF};
        vecs[5]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[6]  = '{MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F};
        vecs[7]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[8]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[9]  = '{DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E};
        vecs[10] = '{MULT,  32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[11] = '{DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003};

        reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; result_req = 1'b1;
        tick(); tick();
        check("reset_busy",  64'(busy),  64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_done",  64'(done),  64'd0);
        check("reset_prod",  prod,       64'd0);
        reset = 1'b1;
        result_req = 1'b0;
        tick();

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // start together with cancel in IDLE is ignored
        start = 1'b1; cancel = 1'b1; op = MULTU; src_a = 32'd9; src_b = 32'd9;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_ignored", 64'(busy), 64'd0);

        // cancel at RUN cycle 10 keeps the previous result
        run_op("pre_cancel", MULTU, 32'h0000_1234, 32'd1, 64'h1234);
        issue(MULTU, 32'd5, 32'd5);
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        dcount = 0;
        repeat (40) begin
            tick();
            if (done) dcount++;
        end
        check("cancel_no_done", 64'(dcount), 64'd0);
        check("cancel_prod_kept", prod, 64'h1234);
        run_op("after_cancel", MULTU, 32'd3, 32'd4, 64'hC);

        // cancel in FIX wins over completion
        issue(MULTU, 32'd7, 32'd7);
        repeat (32) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("fix_cancel_done", 64'(done), 64'd0);
        check("fix_cancel_busy", 64'(busy), 64'd0);
        check("fix_cancel_prod", prod, 64'hC);

        // stall from result_req, then a start held across the busy period
        issue(MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        result_req = 1'b1;
        repeat (5) tick();
        check("stall_result_req", 64'(stall), 64'd1);
        result_req = 1'b0;
        #1;
        check("stall_idle_inputs", 64'(stall), 64'd0);
        start = 1'b1; op = DIV; src_a = 32'hFFFF_FFF9; src_b = 32'h0000_0002;
        #1;
        check("stall_held_start", 64'(stall), 64'd1);
        wait_done(lat);
        check("b2b_first_prod", prod, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b2b_done_cycle_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0;
        check("b2b_second_busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("b2b_second_latency", 64'(lat), 64'd34);
        check("b2b_second_prod", prod, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();

        // asynchronous reset at RUN cycle 20
        saved = prod;
        check("pre_reset_prod_nonzero", 64'(saved != 64'd0), 64'd1);
        issue(MULTU, 32'd11, 32'd13);
        repeat (20) tick();
        result_req = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_busy",  64'(busy),  64'd0);
        check("async_reset_stall", 64'(stall), 64'd0);
        check("async_reset_done",  64'(done),  64'd0);
        check("async_reset_prod",  prod,       64'd0);
        result_req = 1'b0;
        tick();
        reset = 1'b1;
        dcount = 0;
        repeat (40) begin
            tick();
            if (done) dcount++;
        end
        check("reset_no_done", 64'(dcount), 64'd0);
        run_op("after_reset", MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed at 32-bit operands and a 64-bit result.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 src_a  input  32  multiplicand or dividend.
REQ-007 src_b  input  32  multiplier or divisor.
REQ-008 cancel  input  1  abort the operation in flight (pipeline flush).
REQ-009 result_req  input  1  a consumer of prod is present in the decode stage.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 stall  output  1  freeze request to the upstream pipeline registers.
REQ-012 done  output  1  one-cycle pulse marking that prod has just been updated.
REQ-013 prod  output  64  result: [63:32] HI, [31:0] LO; feeds the EX/MEM prod field.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-015 IDLE with start=1 and cancel=0 SHALL take effect at the rising edge:
- latch op and the operand magnitudes (absolute values for MULT/DIV, raw values for MULTU/DIVU);
- latch the sign bits of src_a and src_b;
- clear the bit counter and the partial result;
- move to RUN.
REQ-016 In IDLE, start=1 together with cancel=1 SHALL be ignored.
REQ-017 RUN SHALL process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 RUN SHALL last exactly 32 cycles, with the counter going 0..31; the edge at count 31 SHALL move the FSM to FIX.
REQ-019 The FIX edge SHALL:
- write the sign-corrected result into prod;
- set done=1 for the following cycle only;
- return the FSM to IDLE.
REQ-020 Latency SHALL be 34 rising edges from the start-sampling edge to the edge that updates prod; divide by zero takes the same latency as any other operation.
REQ-021 Multiply results SHALL be:
- MULTU: the 64-bit unsigned product;
- MULT: the 64-bit two's-complement product, negated when sign_a XOR sign_b.
REQ-022 Divide results SHALL place the quotient in LO and the remainder in HI.
- DIV: the quotient is negated when sign_a XOR sign_b.
- DIV: the remainder takes the sign of src_a.
REQ-023 Divide by zero (src_b=0, DIVU or DIV) SHALL give prod = {src_a as latched, 32'hFFFF_FFFF}, with no sign correction and no exception.
REQ-024 DIV 0x8000_0000 / 0xFFFF_FFFF SHALL give LO=0x8000_0000 and HI=0 (wrap, no exception).
REQ-025 busy SHALL be combinational from the state register: busy = (state != IDLE).
REQ-026 stall SHALL be combinational: stall = busy AND (start OR result_req).
REQ-027 A start asserted while busy SHALL be ignored; upstream holds it under stall, and it is accepted at the first IDLE edge.
REQ-028 A start in the same cycle that done is high SHALL be accepted, since the FSM is already in IDLE.
REQ-029 cancel=1 in RUN or FIX SHALL return the FSM to IDLE at the next edge, leave prod unchanged and generate no done pulse; cancel has priority over FIX completion.
REQ-030 Changes on src_a, src_b or op after the accepting edge SHALL have no effect on the operation in flight.
REQ-031 prod SHALL change only on a FIX edge or on reset.

Reset
REQ-032 reset=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE, so busy=0 and stall=0;
- done=0 and prod=0;
- the counter, the operand registers and the partial-result registers to 0.
REQ-033 reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset is released SHALL behave per REQ-015.

Verification
REQ-034 MULT 0xFFFF_FFFF x 0x0000_0002 -> prod 0xFFFF_FFFF_FFFF_FFFE, with done exactly 34 edges after start. The same operands as MULTU -> 0x0000_0001_FFFF_FFFE.
REQ-035 DIV 0xFFFF_FFF9 (-7) / 0x0000_0002 -> LO 0xFFFF_FFFD and HI 0xFFFF_FFFF. The same operands as DIVU -> LO 0x7FFF_FFFC and HI 0x0000_0001.
REQ-036 DIVU 0x0000_0005 / 0 -> prod 0x0000_0005_FFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF -> prod 0x0000_0000_8000_0000.
REQ-037 cancel at RUN cycle 10 after a previous result 0x1234 -> busy=0 next cycle, no done, prod stays 0x1234. A following MULTU 3 x 4 -> prod 0xC.
REQ-038 result_req=1 while busy -> stall=1 until the cycle after the FIX edge. A start held high while busy -> stall=1, accepted at the first IDLE edge, and back-to-back results are both correct.
REQ-039 reset=0 at RUN cycle 20 -> busy, done and prod go to 0 immediately, without a clock edge, and no done pulse follows once reset is released.
